instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: PC_W, default 6, program counter and jump target width.
REQ-002 Parameter: CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; start or continue fetching.
REQ-006 imem_addr  output  PC_W  instruction memory address; always equals current PC.
REQ-007 imem_re  output  1  instruction memory read strobe.
REQ-008 imem_rdata  input  8  instruction word, valid exactly one cycle after imem_re; [7:6] opcode, [5:0] operand.
REQ-009 out_valid  output  1  instruction presented to the control unit.
REQ-010 out_ready  input  1  control unit accepts the presented instruction.
REQ-011 out_opcode  output  2  opcode of presented instruction.
REQ-012 out_operand  output  6  operand of presented instruction.
REQ-013 out_pc  output  PC_W  address of presented instruction.
REQ-014 halted  output  1  fetch stopped by halt opcode.
REQ-015 retired  output  CNT_W  count of accepted handshakes.

Function
REQ-016 States SHALL be IDLE, FETCH, CAPTURE, HOLD and HALT.
REQ-017 IDLE: imem_re=0, out_valid=0; run=1 -> FETCH next cycle, else stay.
REQ-018 FETCH: imem_re=1 for exactly one cycle; -> CAPTURE unconditionally.
REQ-019 CAPTURE: register imem_rdata into out_opcode/out_operand and PC into out_pc; -> HOLD; out_valid=1 from the next cycle.
REQ-020 HOLD: out_valid=1; all out_* stable until out_valid && out_ready.
REQ-021 On a handshake with opcode 2'b11 (j), next PC = operand[PC_W-1:0], zero-extended if PC_W>6.
REQ-022 On any other handshake, next PC = PC+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-023 After a handshake: run=1 -> FETCH; run=0 -> IDLE; out_valid drops the following cycle.
REQ-024 run is sampled only in IDLE and at the handshake; deasserting it in FETCH/CAPTURE/HOLD does not abort the in-flight instruction.
REQ-025 retired increments by 1 on each handshake and wraps at 2^CNT_W.
REQ-026 Throughput: one instruction per 3 cycles with out_ready held 1; run rising to first out_valid = 3 cycles.

Reset
REQ-027 Reset SHALL force state=IDLE, PC=0, out_valid=0, imem_re=0, out_opcode=0, out_operand=0, out_pc=0, halted=0, retired=0.
REQ-028 Reset in any state, including HOLD with an unaccepted instruction, discards that instruction; the instruction is neither counted nor acted on.
REQ-029 Reset has priority over a same-cycle handshake.

Configuration
REQ-030 Macro INSTR_FETCH_HALT_EN defined: a handshake on opcode 2'b10 -> HALT, PC+1 stored, halted=1, imem_re=0; HALT exits only via reset.
REQ-031 Macro undefined: opcode 2'b10 is treated as an ordinary non-jump instruction (REQ-022); HALT is unreachable; halted is tied to 0.

Structure
REQ-032 Shared package processor_pkg holds opcode constants OP_MOV=2'b00, OP_SLL=2'b01, OP_HALT=2'b10, OP_J=2'b11, the instruction field widths and the state encoding type.
REQ-033 The block is a single module with no sub-module.

Verification
REQ-034 Reset, run=1, memory {0:0x41, 1:0x05}, out_ready=1 -> out_valid in cycle 3 with opcode 01, operand 0x01, pc 0; next pc 1; retired=2 after the second handshake.
REQ-035 Word 0xC5 at address 3 -> after its handshake, imem_addr=5 in the next FETCH.
REQ-036 out_ready=0 for 10 cycles in HOLD -> out_* stable, imem_re=0 throughout, retired unchanged.
REQ-037 PC=63 with non-jump word 0x00 accepted -> next imem_addr=0.
REQ-038 Reset asserted in HOLD with out_ready=1 in the same cycle -> retired stays 0, PC=0, state IDLE.
REQ-039 With INSTR_FETCH_HALT_EN defined, word 0x80 accepted -> halted=1, imem_re stays 0 for 20 cycles; with the macro undefined -> fetch continues at PC+1.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: opcode constants, instruction field widths,
// the instruction word layout and the fetch state encoding.
package processor_pkg;

  localparam int OPCODE_W  = 2;
  localparam int OPERAND_W = 6;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_MOV  = 2'b00,
    OP_SLL  = 2'b01,
    OP_HALT = 2'b10,
    OP_J    = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_HOLD,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    opcode_t                opcode;
    logic [OPERAND_W-1:0]   operand;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    return instr_t'(word);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one word per instruction, presents it to the
// control unit with a valid/ready handshake. Define INSTR_FETCH_HALT_EN to enable the halt opcode.
module instr_fetch
  import processor_pkg::*;
#(
  parameter int PC_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic [PC_W-1:0]      imem_addr,
  output logic                 imem_re,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [OPERAND_W-1:0] out_operand,
  output logic [PC_W-1:0]      out_pc,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  instr_t           instr_q, instr_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Jump target is the operand resized to the PC: zero-extended when wider, truncated when narrower.
  logic [PC_W-1:0]  jump_tgt;
  assign jump_tgt = PC_W'(instr_q.operand);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    retired_d = retired_q;
    imem_re   = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_re = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        instr_d  = decode(imem_rdata);
        out_pc_d = pc_q;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          retired_d = retired_q + CNT_W'(1);
          pc_d      = (instr_q.opcode == OP_J) ? jump_tgt : pc_q + PC_W'(1);
          state_d   = run ? S_FETCH : S_IDLE;
`ifdef INSTR_FETCH_HALT_EN
          if (instr_q.opcode == OP_HALT) state_d = S_HALT;
`endif
        end
      end
`ifdef INSTR_FETCH_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over a same-cycle handshake, so an unaccepted instruction is simply dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      out_pc_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      out_pc_q  <= out_pc_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_opcode  = instr_q.opcode;
  assign out_operand = instr_q.operand;
  assign out_pc      = out_pc_q;
  assign retired     = retired_q;

`ifdef INSTR_FETCH_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed programs plus randomized
// memory, stalls and run toggling, checked against a PC/retire reference model.
module tb_instr_fetch;
  import processor_pkg::*;

  localparam int PC_W  = 6;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << PC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_re;
  logic [7:0]       imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_opcode;
  logic [5:0]       out_operand;
  logic [PC_W-1:0]  out_pc;
  logic             halted;
  logic [CNT_W-1:0] retired;

  logic [7:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int exp_pc;
  int exp_retired;
  bit exp_halted;

  instr_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_re     (imem_re),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_operand (out_operand),
    .out_pc      (out_pc),
    .halted      (halted),
    .retired     (retired)
  );

  initial forever #5 clk = ~clk;

  // Synchronous memory: data valid only in the cycle after the read strobe.
  always @(posedge clk) imem_rdata <= imem_re ? mem[imem_addr] : 8'hxx;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next_pc(input int pc, input logic [7:0] word);
    if (word[7:6] == 2'b11) return int'(word[5:0]) % DEPTH;
    return (pc + 1) % DEPTH;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",   out_valid,   0);
    check("rst_imem_re", imem_re,     0);
    check("rst_addr",    imem_addr,   0);
    check("rst_opcode",  out_opcode,  0);
    check("rst_operand", out_operand, 0);
    check("rst_out_pc",  out_pc,      0);
    check("rst_halted",  halted,      0);
    check("rst_retired", retired,     0);
    reset = 1'b0;
    exp_pc = 0;
    exp_retired = 0;
    exp_halted = 1'b0;
  endtask

  // One instruction: wait for presentation, check it, stall, handshake, check the aftermath.
  task automatic txn(input int exp_lat, input int stall, input bit drop_run, input bit run_after);
    int n;
    logic [7:0] w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_run && n == 1) run = 1'b0;
    end while (!out_valid && n < 12);
    check("latency", n, exp_lat);
    w = mem[exp_pc];
    check("out_pc",      out_pc,      exp_pc);
    check("out_opcode",  out_opcode,  w[7:6]);
    check("out_operand", out_operand, w[5:0]);
    check("hold_addr",   imem_addr,   exp_pc);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid",   out_valid,   1);
      check("stall_imem_re", imem_re,     0);
      check("stall_opcode",  out_opcode,  w[7:6]);
      check("stall_operand", out_operand, w[5:0]);
      check("stall_pc",      out_pc,      exp_pc);
      check("stall_retired", retired,     exp_retired);
    end
    run = run_after;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_retired = (exp_retired + 1) % (1 << CNT_W);
`ifdef INSTR_FETCH_HALT_EN
    if (w[7:6] == 2'b10) exp_halted = 1'b1;
`endif
    exp_pc = model_next_pc(exp_pc, w);
    check("post_valid",   out_valid, 0);
    check("post_retired", retired,   exp_retired);
    check("post_halted",  halted,    exp_halted);
    check("post_addr",    imem_addr, exp_pc);
    check("post_imem_re", imem_re,   run_after && !exp_halted);
  endtask

  initial begin
    int lat;
    bit ra;
    reset = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    // Directed program: sll, mov, mov (stalled), j 5, j 63, mov at 63 wrapping to 0.
    mem[0]  = 8'h41;
    mem[1]  = 8'h05;
    mem[2]  = 8'h03;
    mem[3]  = 8'hC5;
    mem[5]  = 8'hFF;
    mem[63] = 8'h00;
    do_reset();
    run = 1'b1;
    txn(3, 0,  0, 1);
    txn(2, 0,  0, 1);
    check("two_retired", retired, 2);
    txn(2, 10, 0, 1);
    txn(2, 0,  0, 1);
    txn(2, 0,  0, 1);
    txn(2, 0,  0, 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_imem_re", imem_re,   0);
      check("idle_valid",   out_valid, 0);
    end

    // Reset arriving together with a handshake discards the instruction.
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    out_ready = 1'b1;
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    exp_pc = 0;
    exp_retired = 0;
    check("hs_rst_retired", retired,   0);
    check("hs_rst_addr",    imem_addr, 0);
    check("hs_rst_valid",   out_valid, 0);
    check("hs_rst_imem_re", imem_re,   0);
    check("hs_rst_out_pc",  out_pc,    0);
    @(negedge clk);
    check("hs_rst_idle_re",    imem_re,   0);
    check("hs_rst_idle_valid", out_valid, 0);

    // Randomized memory image, stalls and run toggling.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'($urandom);
`ifdef INSTR_FETCH_HALT_EN
      if (mem[i][7:6] == 2'b10) mem[i][7:6] = 2'b00;
`endif
    end
    run = 1'b1;
    lat = 3;
    for (int t = 0; t < 150; t++) begin
      ra = ($urandom % 4) != 0;
      txn(lat, (($urandom % 4) == 0) ? $urandom_range(1, 5) : 0, ($urandom % 5) == 0, ra);
      if (ra) begin
        lat = 2;
      end else begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          check("rnd_idle_re",    imem_re,   0);
          check("rnd_idle_valid", out_valid, 0);
        end
        run = 1'b1;
        lat = 3;
      end
    end

    // Halt opcode.
    do_reset();
    mem[0] = 8'h80;
    mem[1] = 8'h41;
    run = 1'b1;
    txn(3, 0, 0, 1);
`ifdef INSTR_FETCH_HALT_EN
    repeat (20) begin
      @(negedge clk);
      check("halt_imem_re", imem_re,   0);
      check("halt_flag",    halted,    1);
      check("halt_valid",   out_valid, 0);
    end
    check("halt_addr", imem_addr, 1);
`else
    txn(2, 0, 0, 1);
    check("nohalt_flag", halted, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
